// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-2 Booth multiplier with start/done handshake
module NOTgate (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       m_inv;
    logic [WIDTH:0]       neg_m;
    logic [WIDTH:0]       a_sum;
    logic [WIDTH:0]       a_sh;
    logic [WIDTH-1:0]     q_sh;

    // A and M carry one guard bit so that -M stays representable when M = -2^(WIDTH-1)
    for (genvar i = 0; i <= WIDTH; i++) begin : g_not
        NOTgate u_not (.a_i(m_q[i]), .y_o(m_inv[i]));
    end

    assign neg_m = m_inv + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        a_sum = a_q;
        case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q + neg_m;
            default: a_sum = a_q;
        endcase
    end

    assign a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
    assign q_sh = {a_sum[0], q_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (count_q == CW'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    q1_d    = 1'b0;
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    count_d = COUNT_INIT;
                end
            end
            S_RUN: begin
                a_d     = a_sh;
                q_d     = q_sh;
                q1_d    = q_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) product_d = {a_sh[WIDTH-1:0], q_sh};
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign product = product_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - self-checking bench for booth_seq_multiplier
module tb_booth_seq_multiplier;
    localparam int W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [W-1:0]      multiplicand = '0;
    logic [W-1:0]      multiplier = '0;
    logic              busy;
    logic              done;
    logic [2*W-1:0]    product;

    int checks = 0;
    int failures = 0;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int p;
        p = a * b;
        return p[2*W-1:0];
    endfunction

    // Model: edges elapsed since the accepted start, or -1 when idle
    int                     ph = -1;
    logic signed [W-1:0]    ma = '0, mb = '0;
    logic [2*W-1:0]         exp_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= -1;
            exp_prod <= '0;
        end else if (ph < 0) begin
            if (start) begin
                ph <= 0;
                ma <= multiplicand;
                mb <= multiplier;
            end
        end else begin
            ph <= (ph == W) ? -1 : ph + 1;
            if (ph == W - 1) exp_prod <= ref_mul(ma, mb);
        end
    end

    int  cyc = 0;
    int  done_cnt = 0;
    int  last_done = -1;
    bit  hold_mode = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            check("busy", busy, (ph >= 0 && ph < W));
            check("done", done, (ph == W));
            check("product", product, exp_prod);
        end
        if (done) begin
            if (hold_mode && last_done >= 0) check("done_period", cyc - last_done, W + 2);
            last_done = cyc;
            done_cnt++;
        end
    end

    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] exp,
                         input bit inject, input string name);
        int n;
        int busy_cyc;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        n = 0;
        busy_cyc = 0;
        while (!done && n < 20) begin
            if (busy) busy_cyc++;
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            start        = inject && (n == 3);
            if (inject && n == 3) begin
                multiplicand = 8'd5;
                multiplier   = 8'd5;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, n, W);
        check({name, "_busy_cycles"}, busy_cyc, W);
        check({name, "_product"}, product, exp);
    endtask

    initial begin
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        do_op(8'd3, 8'hFC, 16'hFFF4, 0, "m3_qm4");
        do_op(8'h80, 8'h80, 16'h4000, 0, "m128sq");
        do_op(8'd127, 8'h80, 16'hC080, 0, "m127_qm128");
        do_op(8'd0, 8'hFF, 16'h0000, 0, "zero");

        do_op(8'd3, 8'hFC, 16'hFFF4, 1, "restart_ignored");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_busy", busy, 0);
            check("hold_product", product, 16'hFFF4);
        end

        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_product", product, 0);
        @(negedge clk);
        check("reset_hold_busy", busy, 0);
        #2 rst_n = 1'b1;
        do_op(8'd7, 8'd9, 16'h003F, 0, "after_reset");

        // Back-to-back: start held high, operands changing every cycle
        @(negedge clk);
        last_done = -1;
        hold_mode = 1;
        begin
            int target;
            int guard;
            target = done_cnt + 1000;
            guard  = 0;
            start  = 1'b1;
            while (done_cnt < target && guard < 1000 * (W + 2) + 200) begin
                case (guard)
                    0:       begin multiplicand = 8'h80; multiplier = 8'h80; end
                    10:      begin multiplicand = 8'h7F; multiplier = 8'h7F; end
                    20:      begin multiplicand = 8'h80; multiplier = 8'h7F; end
                    30:      begin multiplicand = 8'hFF; multiplier = 8'hFF; end
                    default: begin multiplicand = 8'($urandom); multiplier = 8'($urandom); end
                endcase
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            check("random_results", done_cnt, target);
        end
        hold_mode = 0;
        repeat (W + 3) @(negedge clk);
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
